// File: rtl/kernel_load_ctrl.sv
// Kernel reload sequencer: debounces filter/pitch-band selection, snapshots the
// 25-tap kernel on a frame boundary, streams it over valid/ready and pulses a bank swap.
module kernel_load_ctrl #(
    parameter int STABLE_CYCLES    = 8,
    parameter int PITCH_BAND_SHIFT = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        filter_number,
    input  logic [15:0]       audio_pitch,
    input  logic              frame_start,
    input  logic [24:0][6:0]  kernel_in,
    input  logic              coef_ready,
    output logic              coef_valid,
    output logic signed [6:0] coef_data,
    output logic [4:0]        coef_index,
    output logic              coef_last,
    output logic              bank_swap,
    output logic              busy,
    output logic              load_overrun
);

    localparam int SEL_W = 19;
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [4:0] LAST_IDX = 5'd24;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STABLE,
        ARMED,
        LOAD,
        SWAP
    } state_t;

    state_t state, next_state;

    logic [SEL_W-1:0] sel, sel_q, loaded_sel;
    logic             pending;
    logic [CNT_W-1:0] stable_cnt;
    logic [4:0]       idx;
    logic [24:0][6:0] snap;
    logic             restart_cnt, inc_cnt, capture, beat_done;

    // The full shifted pitch is kept so only the band bits can differ between selections.
    assign sel = {filter_number, audio_pitch >> PITCH_BAND_SHIFT};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        restart_cnt = 1'b0;
        inc_cnt     = 1'b0;
        capture     = 1'b0;
        beat_done   = 1'b0;
        case (state)
            IDLE: begin
                if (sel != loaded_sel || pending) begin
                    restart_cnt = 1'b1;
                    next_state  = WAIT_STABLE;
                end
            end
            WAIT_STABLE: begin
                if (sel == loaded_sel && !pending) begin
                    next_state = IDLE;
                end else if (sel != sel_q) begin
                    restart_cnt = 1'b1;
                end else if (stable_cnt == CNT_MAX) begin
                    next_state = ARMED;
                end else begin
                    inc_cnt = 1'b1;
                end
            end
            ARMED: begin
                if (sel != sel_q) begin
                    restart_cnt = 1'b1;
                    next_state  = WAIT_STABLE;
                end else if (frame_start) begin
                    capture    = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (coef_ready) begin
                    beat_done = 1'b1;
                    if (idx == LAST_IDX) begin
                        next_state = SWAP;
                    end
                end
            end
            SWAP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // pending survives reset as 1 so the first frame after reset always reloads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q        <= '0;
            loaded_sel   <= '0;
            pending      <= 1'b1;
            stable_cnt   <= '0;
            idx          <= '0;
            snap         <= '0;
            load_overrun <= 1'b0;
        end else begin
            if (restart_cnt) begin
                stable_cnt <= '0;
                sel_q      <= sel;
            end else if (inc_cnt) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            if (capture) begin
                snap       <= kernel_in;
                loaded_sel <= sel;
                pending    <= 1'b0;
                idx        <= '0;
            end else if (beat_done) begin
                idx <= (idx == LAST_IDX) ? 5'd0 : idx + 5'd1;
            end
            load_overrun <= frame_start && (state == LOAD || state == SWAP);
        end
    end

    assign coef_valid = (state == LOAD);
    assign coef_data  = coef_valid ? $signed(snap[idx]) : 7'sd0;
    assign coef_index = coef_valid ? idx : 5'd0;
    assign coef_last  = coef_valid && (idx == LAST_IDX);
    assign bank_swap  = (state == SWAP);
    assign busy       = (state == LOAD) || (state == SWAP);

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// Directed bench for kernel_load_ctrl: a table of selection steps plus
// hand-written sequences for stalls, aborted toggles, overrun and mid-load reset.
module tb_kernel_load_ctrl;

    logic              clk;
    logic              reset;
    logic [2:0]        filter_number;
    logic [15:0]       audio_pitch;
    logic              frame_start;
    logic [24:0][6:0]  kernel_drv;
    logic              coef_ready;
    logic              coef_valid;
    logic signed [6:0] coef_data;
    logic [4:0]        coef_index;
    logic              coef_last;
    logic              bank_swap;
    logic              busy;
    logic              load_overrun;

    logic [24:0][6:0]  exp_kernel;
    int                checks;
    int                errors;

    typedef struct {
        logic [2:0]  filt;
        logic [15:0] pitch;
        int          kind;
        bit          rand_ready;
        bit          exp_reload;
    } step_t;

    step_t steps[5];

    kernel_load_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .filter_number (filter_number),
        .audio_pitch   (audio_pitch),
        .frame_start   (frame_start),
        .kernel_in     (kernel_drv),
        .coef_ready    (coef_ready),
        .coef_valid    (coef_valid),
        .coef_data     (coef_data),
        .coef_index    (coef_index),
        .coef_last     (coef_last),
        .bank_swap     (bank_swap),
        .busy          (busy),
        .load_overrun  (load_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Kernel shapes standing in for convolution_filt; kind 0 has tap 12 = 41, kind 2 is identity.
    function automatic logic [24:0][6:0] make_kernel(input int kind);
        logic [24:0][6:0] k;
        for (int i = 0; i < 25; i++) begin
            case (kind)
                0:       k[i] = 7'(29 + i);
                1:       k[i] = 7'(i - 12);
                2:       k[i] = (i == 12) ? 7'd1 : 7'd0;
                3:       k[i] = 7'(i * 5 - 60);
                default: k[i] = (i % 2 == 0) ? 7'd63 : 7'h40;
            endcase
        end
        return k;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] filt, input logic [15:0] pitch);
        filter_number = filt;
        audio_pitch   = pitch;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        exp_kernel  = kernel_drv;
    endtask

    task automatic watch_idle(input string tag, input int cycles);
        int valids, swaps, ovr, busies;
        valids = 0; swaps = 0; ovr = 0; busies = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (coef_valid)   valids++;
            if (bank_swap)    swaps++;
            if (load_overrun) ovr++;
            if (busy)         busies++;
        end
        checkOutput({tag, " valid_cycles"}, valids, 0);
        checkOutput({tag, " swaps"}, swaps, 0);
        checkOutput({tag, " overruns"}, ovr, 0);
        checkOutput({tag, " busy_cycles"}, busies, 0);
    endtask

    // Follows one load from the cycle after the capturing frame_start to just past the swap.
    task automatic watch_load(input string tag, input bit rand_ready, input int overrun_beat);
        int beats, swaps, ovr, first_c, last_c, swap_c;
        bit order_ok, data_ok, last_ok, hold_ok, stalled, injected;
        logic [6:0] pdata;
        logic [4:0] pidx;
        beats = 0; swaps = 0; ovr = 0; first_c = -1; last_c = -1; swap_c = -1;
        order_ok = 1; data_ok = 1; last_ok = 1; hold_ok = 1; stalled = 0; injected = 0;
        pdata = '0; pidx = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (load_overrun) ovr++;
            if (bank_swap) begin
                swaps++;
                if (swap_c < 0) swap_c = c;
            end
            if (coef_valid) begin
                if (first_c < 0) first_c = c;
                if (stalled && (coef_data !== pdata || coef_index !== pidx)) hold_ok = 0;
                if (coef_index != 5'(beats)) order_ok = 0;
                if (beats < 25 && coef_data !== exp_kernel[beats]) data_ok = 0;
                if (coef_last !== (coef_index == 5'd24)) last_ok = 0;
                if (overrun_beat >= 0 && !injected && int'(coef_index) == overrun_beat) begin
                    frame_start = 1'b1;
                    injected    = 1;
                end
                coef_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                stalled    = !coef_ready;
                pdata      = coef_data;
                pidx       = coef_index;
                if (coef_ready) begin
                    beats++;
                    if (coef_index == 5'd24) last_c = c;
                end
            end else begin
                stalled    = 0;
                coef_ready = 1'b1;
            end
            if (c == 5) kernel_drv = ~exp_kernel;
            if (swap_c >= 0 && c >= swap_c + 2) break;
        end
        coef_ready  = 1'b1;
        frame_start = 1'b0;
        kernel_drv  = exp_kernel;
        checkOutput({tag, " first_valid_cycle"}, first_c, 0);
        checkOutput({tag, " beats"}, beats, 25);
        checkOutput({tag, " index_order"}, int'(order_ok), 1);
        checkOutput({tag, " tap_data"}, int'(data_ok), 1);
        checkOutput({tag, " coef_last"}, int'(last_ok), 1);
        checkOutput({tag, " stall_hold"}, int'(hold_ok), 1);
        checkOutput({tag, " swaps"}, swaps, 1);
        checkOutput({tag, " swap_after_last"}, swap_c - last_c, 1);
        checkOutput({tag, " overruns"}, ovr, (overrun_beat >= 0) ? 1 : 0);
        if (!rand_ready) checkOutput({tag, " swap_cycle"}, swap_c, 25);
        checkOutput({tag, " busy_after"}, int'(busy), 0);
        checkOutput({tag, " valid_after"}, int'(coef_valid), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit found;
        checks = 0;
        errors = 0;

        steps[0] = '{3'd3, 16'd64,  1, 1'b1, 1'b1};
        steps[1] = '{3'd3, 16'd100, 1, 1'b0, 1'b0};
        steps[2] = '{3'd3, 16'd100, 1, 1'b0, 1'b0};
        steps[3] = '{3'd3, 16'd127, 1, 1'b0, 1'b0};
        steps[4] = '{3'd3, 16'd175, 2, 1'b0, 1'b1};

        reset       = 1'b1;
        frame_start = 1'b0;
        coef_ready  = 1'b1;
        kernel_drv  = make_kernel(0);
        exp_kernel  = kernel_drv;
        applyStimulus(3'd1, 16'd0);
        settle(3);
        checkOutput("reset coef_valid", int'(coef_valid), 0);
        checkOutput("reset coef_data", int'(coef_data), 0);
        checkOutput("reset coef_index", int'(coef_index), 0);
        checkOutput("reset coef_last", int'(coef_last), 0);
        checkOutput("reset bank_swap", int'(bank_swap), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset load_overrun", int'(load_overrun), 0);
        reset = 1'b0;

        // First load is forced by the pending flag set at reset.
        settle(12);
        pulse_frame();
        watch_load("t1", 1'b0, -1);

        foreach (steps[s]) begin
            applyStimulus(steps[s].filt, steps[s].pitch);
            kernel_drv = make_kernel(steps[s].kind);
            settle(12);
            pulse_frame();
            if (steps[s].exp_reload) watch_load($sformatf("step%0d", s), steps[s].rand_ready, -1);
            else                     watch_idle($sformatf("step%0d", s), 30);
        end

        // A short-lived filter change that reverts before becoming stable must not reload.
        @(negedge clk);
        applyStimulus(3'd4, 16'd175);
        settle(3);
        applyStimulus(3'd3, 16'd175);
        settle(12);
        pulse_frame();
        watch_idle("t4", 30);

        // frame_start during a load only flags an overrun.
        applyStimulus(3'd5, 16'd175);
        kernel_drv = make_kernel(3);
        settle(12);
        pulse_frame();
        watch_load("t5", 1'b0, 10);

        // Reset in the middle of a load; the next armed frame reloads the same kernel.
        applyStimulus(3'd6, 16'd0);
        kernel_drv = make_kernel(4);
        settle(12);
        pulse_frame();
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            frame_start = 1'b0;
            coef_ready  = 1'b1;
            if (coef_valid && coef_index == 5'd12) begin
                found = 1;
                break;
            end
        end
        checkOutput("t6 reached beat 12", int'(found), 1);
        reset = 1'b1;
        #1;
        checkOutput("t6 async valid", int'(coef_valid), 0);
        checkOutput("t6 async bank_swap", int'(bank_swap), 0);
        checkOutput("t6 async busy", int'(busy), 0);
        checkOutput("t6 async index", int'(coef_index), 0);
        @(negedge clk);
        reset = 1'b0;
        settle(12);
        pulse_frame();
        watch_load("t6 reload", 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
